// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write scheduler.
package rf_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int LINK_REG = 31;
  localparam int ZERO_REG = 0;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2,
    WB_LINK = 2'd3
  } wb_src_t;

endpackage

// File: rtl/rf_write_sched_rr_arb2.sv
// Two-way round-robin arbiter (req[0] = ALU, req[1] = MEM); owns the rr pointer.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic rr_reg;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) gnt = rr_reg ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // Pointer only moves on a real grant; a disabled cycle (link won) leaves it alone.
  always_ff @(posedge clock) begin
    if (reset)       rr_reg <= 1'b0;
    else if (gnt[0]) rr_reg <= 1'b1;
    else if (gnt[1]) rr_reg <= 1'b0;
  end

endmodule

// File: rtl/rf_write_sched.sv
// Write-port scheduler and RAW scoreboard for registerBench.
// Build option: define RF_LINK_WRITE_EN to enable the jump-and-link write source.
module rf_write_sched #(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              link_valid,
  output logic              link_ready,
  input  logic [DATA_W-1:0] link_pc,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);
  import rf_pkg::*;

  localparam int NREGS = 1 << ADDR_W;

  logic              link_win;
  logic [1:0]        gnt;
  wb_src_t           sel;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;
  logic [NREGS-1:0]  pend_reg;
  logic [NREGS-1:0]  pend_next;
  logic              rf_we_reg;
  logic [ADDR_W-1:0] rf_waddr_reg;
  logic [DATA_W-1:0] rf_wdata_reg;

`ifdef RF_LINK_WRITE_EN
  assign link_win = link_valid;
`else
  logic unused_link;
  assign link_win    = 1'b0;
  assign unused_link = ^{link_valid, link_pc};
`endif

  assign link_ready = link_win;

  rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    ({mem_valid, alu_valid}),
    .enable (!link_win),
    .gnt    (gnt)
  );

  assign alu_ready = gnt[0];
  assign mem_ready = gnt[1];

  always_comb begin
    sel        = WB_NONE;
    grant_addr = '0;
    grant_data = '0;
    if (link_win) begin
      sel        = WB_LINK;
      grant_addr = ADDR_W'(LINK_REG);
      grant_data = link_pc + DATA_W'(1);
    end else if (gnt[0]) begin
      sel        = WB_ALU;
      grant_addr = alu_addr;
      grant_data = alu_data;
    end else if (gnt[1]) begin
      sel        = WB_MEM;
      grant_addr = mem_addr;
      grant_data = mem_data;
    end
  end

  // Set-before-clear per bit: an issue in the same cycle as a commit keeps the register pending.
  assign pend_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_pend
      assign pend_next[gi] = (issue_valid && issue_addr == ADDR_W'(gi)) ||
                             (pend_reg[gi] && !(rf_we_reg && rf_waddr_reg == ADDR_W'(gi)));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
      pend_reg     <= '0;
    end else begin
      rf_we_reg <= (sel != WB_NONE) && (grant_addr != ADDR_W'(ZERO_REG));
      if (sel != WB_NONE) begin
        rf_waddr_reg <= grant_addr;
        rf_wdata_reg <= grant_data;
      end
      pend_reg <= pend_next;
    end
  end

  assign stall    = pend_reg[chk_addr1] | pend_reg[chk_addr2];
  assign rf_we    = rf_we_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;

endmodule

// File: tb/tb_rf_write_sched.sv
// Directed self-checking bench for rf_write_sched (works with or without RF_LINK_WRITE_EN).
module tb_rf_write_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        link_valid, link_ready;
  logic [31:0] link_pc;
  logic        issue_valid;
  logic [4:0]  issue_addr, chk_addr1, chk_addr2;
  logic        stall, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  rf_write_sched dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .link_valid(link_valid), .link_ready(link_ready), .link_pc(link_pc),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .stall(stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    link_valid = 0; link_pc = 0;
    issue_valid = 0; issue_addr = 0;
    chk_addr1 = 0; chk_addr2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_addr1 = 7; chk_addr2 = 31;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got=%0d want=0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h want=0", rf_wdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall); end
    checks++; if ({alu_ready, mem_ready, link_ready} !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b want=000", {alu_ready, mem_ready, link_ready}); end
    $display("txn reset: we=%b waddr=%0d wdata=%h", rf_we, rf_waddr, rf_wdata);
  endtask

  task automatic test_alu_write();
    do_reset();
    alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got=%b want=1", alu_ready); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL alu_memready got=%b want=0", mem_ready); end
    tick();
    alu_valid = 0;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL alu_we got=%b want=1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr got=%0d want=5", rf_waddr); end
    checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wdata got=%h want=deadbeef", rf_wdata); end
    $display("txn alu write: addr=%0d data=%h", rf_waddr, rf_wdata);
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL alu_we_drop got=%b want=0", rf_we); end
  endtask

  task automatic test_contention();
    logic [4:0] exp_addr;
    do_reset();
    alu_valid = 1; alu_addr = 3; alu_data = 32'hA0A0_0003;
    mem_valid = 1; mem_addr = 4; mem_data = 32'hB0B0_0004;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({mem_ready, alu_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL contention_gnt%0d got=%b want=%b", i, {mem_ready, alu_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      exp_addr = (i % 2 == 0) ? 5'd3 : 5'd4;
      tick();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== exp_addr) begin
        errors++; $display("FAIL contention_commit%0d got=%b/%0d want=1/%0d", i, rf_we, rf_waddr, exp_addr);
      end
      $display("txn contention %0d: waddr=%0d wdata=%h", i, rf_waddr, rf_wdata);
    end
    idle_inputs();
  endtask

  task automatic test_link();
    do_reset();
    alu_valid = 1; alu_addr = 3; alu_data = 32'h0000_0333;
    mem_valid = 1; mem_addr = 4; mem_data = 32'h0000_0444;
    link_valid = 1; link_pc = 32'h10;
    #1;
`ifdef RF_LINK_WRITE_EN
    checks++; if ({link_ready, alu_ready, mem_ready} !== 3'b100) begin errors++; $display("FAIL link_prio got=%b want=100", {link_ready, alu_ready, mem_ready}); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'h11) begin errors++; $display("FAIL link_commit got=%b/%0d/%h want=1/31/00000011", rf_we, rf_waddr, rf_wdata); end
    $display("txn link: waddr=%0d wdata=%h", rf_waddr, rf_wdata);
    link_pc = 32'hFFFF_FFFF;
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'h0) begin errors++; $display("FAIL link_wrap got=%b/%0d/%h want=1/31/00000000", rf_we, rf_waddr, rf_wdata); end
    $display("txn link wrap: waddr=%0d wdata=%h", rf_waddr, rf_wdata);
    link_valid = 0;
    #1;
    // link grants must not have moved rr, so ALU still wins
    checks++; if ({mem_ready, alu_ready} !== 2'b01) begin errors++; $display("FAIL link_rr_kept got=%b want=01", {mem_ready, alu_ready}); end
`else
    checks++; if ({link_ready, alu_ready, mem_ready} !== 3'b010) begin errors++; $display("FAIL nolink_gnt got=%b want=010", {link_ready, alu_ready, mem_ready}); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h333) begin errors++; $display("FAIL nolink_commit got=%b/%0d/%h want=1/3/00000333", rf_we, rf_waddr, rf_wdata); end
    $display("txn link disabled: waddr=%0d wdata=%h", rf_waddr, rf_wdata);
`endif
    idle_inputs();
    tick();
  endtask

  task automatic test_scoreboard();
    do_reset();
    chk_addr1 = 7; chk_addr2 = 0;
    issue_valid = 1; issue_addr = 7;               // cycle 0
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_stall_c0 got=%b want=0", stall); end
    tick(); issue_valid = 0;                       // cycle 1
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall_c%0d got=%b want=1", c, stall); end
      tick();
    end
    mem_valid = 1; mem_addr = 7; mem_data = 32'h77;  // cycle 4
    #1;
    checks++; if (mem_ready !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL sb_c4 got=%b%b want=11", mem_ready, stall); end
    tick(); mem_valid = 0;                         // cycle 5
    checks++; if (rf_we !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL sb_c5 got=%b%b want=11", rf_we, stall); end
    tick();                                        // cycle 6
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_c6 got=%b want=0", stall); end
    $display("txn scoreboard: addr 7 cleared after commit");

    issue_valid = 1; issue_addr = 7;
    tick(); issue_valid = 0;
    mem_valid = 1; mem_addr = 7; mem_data = 32'h78;
    tick(); mem_valid = 0;
    issue_valid = 1; issue_addr = 7;               // re-issue while commit is in flight
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin errors++; $display("FAIL sb_same_commit got=%b/%0d want=1/7", rf_we, rf_waddr); end
    tick(); issue_valid = 0;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_set_wins got=%b want=1", stall); end
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_set_holds got=%b want=1", stall); end
    $display("txn scoreboard: set wins over clear");
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    do_reset();
    chk_addr1 = 0; chk_addr2 = 0;
    issue_valid = 1; issue_addr = 0;
    alu_valid = 1; alu_addr = 0; alu_data = 32'h1234_5678;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got=%b want=1", alu_ready); end
    tick();
    idle_inputs();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL zero_we got=%b want=0", rf_we); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got=%b want=0", stall); end
    $display("txn zero reg: we=%b stall=%b", rf_we, stall);
  endtask

  task automatic test_back_to_back();
    do_reset();
    alu_valid = 1;
    for (int i = 0; i < 3; i++) begin
      alu_addr = 5'(10 + i); alu_data = 32'hC000_0000 + 32'(i);
      tick();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(10 + i) || rf_wdata !== 32'hC000_0000 + 32'(i)) begin
        errors++; $display("FAIL b2b_%0d got=%b/%0d/%h want=1/%0d/%h", i, rf_we, rf_waddr, rf_wdata, 10 + i, 32'hC000_0000 + 32'(i));
      end
      $display("txn back-to-back %0d: waddr=%0d wdata=%h", i, rf_waddr, rf_wdata);
    end
    idle_inputs();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    alu_valid = 1; alu_addr = 9; alu_data = 32'h99;
    mem_valid = 1; mem_addr = 12; mem_data = 32'hCC;
    issue_valid = 1; issue_addr = 9;
    chk_addr1 = 9;
    tick();                                        // ALU granted; rr now prefers MEM
    idle_inputs(); chk_addr1 = 9;
    reset = 1;
    tick();
    reset = 0;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL midrst_we got=%b want=0", rf_we); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall got=%b want=0", stall); end
    alu_valid = 1; alu_addr = 3; mem_valid = 1; mem_addr = 4;
    #1;
    checks++; if ({mem_ready, alu_ready} !== 2'b01) begin errors++; $display("FAIL midrst_rr got=%b want=01", {mem_ready, alu_ready}); end
    $display("txn reset mid-stream: we=%b stall=%b", rf_we, stall);
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    tick();
    test_reset();
    test_alu_write();
    test_contention();
    test_link();
    test_scoreboard();
    test_zero_reg();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
